// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined chunk adder.
//   add_op_e      : operation select carried on the 'sub' wire.
//   DEFAULT_WIDTH : default operand/result width.
//   DEFAULT_CHUNK : default bits resolved per pipeline stage.
//   ref_add()     : behavioural sum/cout/ovf at DEFAULT_WIDTH, used as a
//                   reference model; not used by the datapath itself.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic {
    ADD_OP = 1'b0,
    SUB_OP = 1'b1
  } add_op_e;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] sum;
    logic                     cout;
    logic                     ovf;
  } add_result_t;

  // Subtraction is a + ~b + ~cin, so cout is the raw carry (not-borrow)
  // and ovf is the usual two's-complement same-sign/different-result rule
  // applied to the conditioned operand.
  function automatic add_result_t ref_add(
    input logic [DEFAULT_WIDTH-1:0] a,
    input logic [DEFAULT_WIDTH-1:0] b,
    input logic                     cin,
    input add_op_e                  op
  );
    logic [DEFAULT_WIDTH-1:0] b_eff;
    logic                     c0;
    logic [DEFAULT_WIDTH:0]   full;
    add_result_t              r;
    b_eff  = (op == SUB_OP) ? ~b : b;
    c0     = (op == SUB_OP) ? ~cin : cin;
    full   = {1'b0, a} + {1'b0, b_eff} + {{DEFAULT_WIDTH{1'b0}}, c0};
    r.sum  = full[DEFAULT_WIDTH-1:0];
    r.cout = full[DEFAULT_WIDTH];
    r.ovf  = (a[DEFAULT_WIDTH-1] == b_eff[DEFAULT_WIDTH-1]) &&
             (r.sum[DEFAULT_WIDTH-1] != a[DEFAULT_WIDTH-1]);
    return r;
  endfunction

endpackage

// File: rtl/pipelined_chunk_adder_if.sv
// Operand/result handshake bundle for pipelined_chunk_adder.
//   Upstream  : in_valid, in_ready, a, b, cin, sub
//   Downstream: out_valid, out_ready, sum, cout, ovf
// Modports:
//   master : the side that supplies operands and consumes results.
//   slave  : the adder itself.
interface pipelined_chunk_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/adder_slice.sv
// Combinational W-bit ripple of full-add cells: one pipeline stage's
// worth of carry chain.
//   a, b : operand chunks (b already conditioned for subtract)
//   cin  : carry into bit 0
//   sum  : chunk sum
//   cout : carry out of bit W-1
module adder_slice
  import adder_pkg::*;
#(
  parameter int W = DEFAULT_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[W];

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit add/subtract with carry-in. The carry chain is cut
// into CHUNK-bit slices with one register stage per slice, giving a
// latency of STAGES = WIDTH/CHUNK cycles at one operation per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (clears every register)
//   bus  : pipelined_chunk_adder_if.slave
//          in_valid/in_ready/a/b/cin/sub  operand beat
//          out_valid/out_ready/sum/cout/ovf result beat
// Flow control is a global stall: every register, valid bits included,
// moves only when the output slot is free or being drained.
module pipelined_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_chunk_adder_if.slave bus
);

  // Guards the division below so a bad CHUNK reaches the $error rather
  // than a divide-by-zero during elaboration.
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STAGES     = WIDTH / CHUNK_SAFE;

  if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
    $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  function automatic logic signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic              advance;
  logic [WIDTH-1:0]  b_eff_p0;
  logic              c0_p0;

  // Operand chunks as they arrive at their own stage (after skew).
  logic [WIDTH-1:0]  a_stg;
  logic [WIDTH-1:0]  b_stg;
  logic [STAGES-1:0] cin_stg;

  logic [WIDTH-1:0]  stg_sum_d;
  logic [WIDTH-1:0]  stg_sum_q;
  logic [STAGES-1:0] carry_d;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vld_q;
  logic              ovf_d;
  logic              ovf_q;

  // Result chunks after deskew, all aligned to the same beat.
  logic [WIDTH-1:0]  sum_out;

  // ---- stage 0 input: operand conditioning (combinational) ----
  always_comb begin
    b_eff_p0 = (add_op_e'(bus.sub) == SUB_OP) ? ~bus.b   : bus.b;
    c0_p0    = (add_op_e'(bus.sub) == SUB_OP) ? ~bus.cin : bus.cin;
  end

  assign advance      = bus.out_ready || !vld_q[STAGES-1];
  assign bus.in_ready = advance;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = bus.in_valid;
    for (int s = 1; s < STAGES; s++) begin
      vld_d[s] = vld_q[s-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    localparam int LO  = k * CHUNK_SAFE;
    localparam int DSK = STAGES - 1 - k;

    // ---- skew: chunk k waits k cycles before its stage ----
    if (k == 0) begin : g_skew_none
      assign a_stg[LO +: CHUNK_SAFE] = bus.a[LO +: CHUNK_SAFE];
      assign b_stg[LO +: CHUNK_SAFE] = b_eff_p0[LO +: CHUNK_SAFE];
      assign cin_stg[k]              = c0_p0;
    end else begin : g_skew
      logic [2*CHUNK_SAFE-1:0] skew_d [k];
      logic [2*CHUNK_SAFE-1:0] skew_q [k];

      always_comb begin
        skew_d[0] = {bus.a[LO +: CHUNK_SAFE], b_eff_p0[LO +: CHUNK_SAFE]};
        for (int i = 1; i < k; i++) begin
          skew_d[i] = skew_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            skew_q[i] <= '0;
          end
        end else if (advance) begin
          for (int i = 0; i < k; i++) begin
            skew_q[i] <= skew_d[i];
          end
        end
      end

      assign {a_stg[LO +: CHUNK_SAFE], b_stg[LO +: CHUNK_SAFE]} = skew_q[k-1];
      // The previous stage registered this beat's carry one cycle ago,
      // which lines up with the chunk leaving the skew line now.
      assign cin_stg[k] = carry_q[k-1];
    end

    // ---- stage k: ripple one chunk ----
    adder_slice #(
      .W (CHUNK_SAFE)
    ) u_slice (
      .a    (a_stg[LO +: CHUNK_SAFE]),
      .b    (b_stg[LO +: CHUNK_SAFE]),
      .cin  (cin_stg[k]),
      .sum  (stg_sum_d[LO +: CHUNK_SAFE]),
      .cout (carry_d[k])
    );

    // ---- deskew: chunk k waits STAGES-1-k cycles after its stage ----
    if (DSK == 0) begin : g_dsk_none
      assign sum_out[LO +: CHUNK_SAFE] = stg_sum_q[LO +: CHUNK_SAFE];
    end else begin : g_dsk
      logic [CHUNK_SAFE-1:0] dsk_d [DSK];
      logic [CHUNK_SAFE-1:0] dsk_q [DSK];

      always_comb begin
        dsk_d[0] = stg_sum_q[LO +: CHUNK_SAFE];
        for (int i = 1; i < DSK; i++) begin
          dsk_d[i] = dsk_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DSK; i++) begin
            dsk_q[i] <= '0;
          end
        end else if (advance) begin
          for (int i = 0; i < DSK; i++) begin
            dsk_q[i] <= dsk_d[i];
          end
        end
      end

      assign sum_out[LO +: CHUNK_SAFE] = dsk_q[DSK-1];
    end
  end

  // The MSB chunk's operand bits reach the last stage together with the
  // final carry, so overflow is resolved there and registered with cout.
  assign ovf_d = signed_ovf(a_stg[WIDTH-1], b_stg[WIDTH-1], stg_sum_d[WIDTH-1]);

  // ---- stage registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      stg_sum_q <= '0;
      carry_q   <= '0;
      ovf_q     <= 1'b0;
    end else if (advance) begin
      vld_q     <= vld_d;
      stg_sum_q <= stg_sum_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
    end
  end

  // ---- output ----
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = sum_out;
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
module tb_pipelined_chunk_adder;
  import adder_pkg::*;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pipelined_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_chunk_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic sb);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.sub      = sb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.sum !== 32'h0) begin failures++; $display("FAIL reset_sum: got %h want 0", bus.sum); end
    checks++;
    if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got cout=%b ovf=%b want 0 0", bus.cout, bus.ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_single_add();
    int n;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (n != STAGES) begin failures++; $display("FAIL single_latency: got %0d want %0d", n, STAGES); end
    checks++;
    if (bus.sum !== 32'h0000_0007) begin failures++; $display("FAIL single_sum: got %h want 00000007", bus.sum); end
    checks++;
    if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL single_flags: got cout=%b ovf=%b want 0 0", bus.cout, bus.ovf);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_no_dup: got %b want 0", bus.out_valid); end
  endtask

  // Hand-computed vectors: ripple through every chunk, chunk-boundary
  // carries, subtract with borrow-in, and both signed overflow directions.
  task automatic test_directed();
    vec_t v [9];
    int   n;
    v[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, s: 32'h0000_0000, co: 1'b1, ov: 1'b0};
    v[1] = '{a: 32'h8000_0000, b: 32'h0000_0001, cin: 1'b0, sub: 1'b1, s: 32'h7FFF_FFFF, co: 1'b1, ov: 1'b1};
    v[2] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, s: 32'h8000_0000, co: 1'b0, ov: 1'b1};
    v[3] = '{a: 32'h0000_000A, b: 32'h0000_0003, cin: 1'b1, sub: 1'b1, s: 32'h0000_0006, co: 1'b1, ov: 1'b0};
    v[4] = '{a: 32'h1234_5678, b: 32'h1111_1111, cin: 1'b1, sub: 1'b0, s: 32'h2345_678A, co: 1'b0, ov: 1'b0};
    v[5] = '{a: 32'h0000_0000, b: 32'h0000_0001, cin: 1'b0, sub: 1'b1, s: 32'hFFFF_FFFF, co: 1'b0, ov: 1'b0};
    v[6] = '{a: 32'h0000_00FF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, s: 32'h0000_0100, co: 1'b0, ov: 1'b0};
    v[7] = '{a: 32'h00FF_FF00, b: 32'h0000_0100, cin: 1'b0, sub: 1'b0, s: 32'h0100_0000, co: 1'b0, ov: 1'b0};
    v[8] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, cin: 1'b1, sub: 1'b0, s: 32'h0000_0000, co: 1'b1, ov: 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, v[i].a, v[i].b, v[i].cin, v[i].sub);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      n = 1;
      while (bus.out_valid !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      checks++;
      if (n != STAGES) begin failures++; $display("FAIL vec%0d_latency: got %0d want %0d", i, n, STAGES); end
      checks++;
      if (bus.sum !== v[i].s) begin failures++; $display("FAIL vec%0d_sum: got %h want %h", i, bus.sum, v[i].s); end
      checks++;
      if (bus.cout !== v[i].co) begin failures++; $display("FAIL vec%0d_cout: got %b want %b", i, bus.cout, v[i].co); end
      checks++;
      if (bus.ovf !== v[i].ov) begin failures++; $display("FAIL vec%0d_ovf: got %b want %b", i, bus.ovf, v[i].ov); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    add_result_t      exp_q [$];
    add_result_t      e;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sb;
    int               got;
    logic             want_vld;
    got = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 + STAGES + 2; i++) begin
      if (i < 100) begin
        if (i == 50) begin
          a = 32'd10; b = 32'd3; ci = 1'b1; sb = 1'b1;
        end else begin
          a  = $urandom;
          b  = $urandom;
          ci = 1'($urandom_range(0, 1));
          sb = 1'($urandom_range(0, 1));
        end
        drive(1'b1, a, b, ci, sb);
        exp_q.push_back(ref_add(a, b, ci, add_op_e'(sb)));
      end else begin
        drive(1'b0, '0, '0, 1'b0, 1'b0);
      end
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      tick();
      want_vld = (i >= STAGES - 1) && (i < 100 + STAGES - 1);
      checks++;
      if (bus.out_valid !== want_vld) begin
        failures++; $display("FAIL stream_valid[%0d]: got %b want %b", i, bus.out_valid, want_vld);
      end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.sum !== e.sum || bus.cout !== e.cout || bus.ovf !== e.ovf) begin
          failures++;
          $display("FAIL stream_beat%0d: got %h/%b/%b want %h/%b/%b", got, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
        end
        if (got == 50) begin
          checks++;
          if (bus.sum !== 32'd6) begin failures++; $display("FAIL stream_sub_borrow: got %h want 00000006", bus.sum); end
        end
        got++;
      end
    end
    checks++;
    if (got != 100) begin failures++; $display("FAIL stream_count: got %0d want 100", got); end
  endtask

  task automatic test_backpressure();
    add_result_t      exp_q [$];
    logic [WIDTH-1:0] ba [8];
    logic [WIDTH-1:0] bb [8];
    logic             bs [8];
    int               nxt;
    for (int i = 0; i < 8; i++) begin
      ba[i] = 32'h0101_0101 * (i + 1);
      bb[i] = 32'hF0F0_F0F0 + i;
      bs[i] = i[0];
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      drive(1'b1, ba[i], bb[i], 1'b0, bs[i]);
      tick();
      exp_q.push_back(ref_add(ba[i], bb[i], 1'b0, add_op_e'(bs[i])));
    end
    nxt = STAGES;
    drive(1'b1, ba[nxt], bb[nxt], 1'b0, bs[nxt]);
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_full: got out_valid=%b want 1", bus.out_valid); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus.in_ready); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== exp_q[0].sum || bus.cout !== exp_q[0].cout || bus.ovf !== exp_q[0].ovf) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got %b %h/%b/%b want 1 %h/%b/%b", c, bus.out_valid, bus.sum, bus.cout, bus.ovf,
                 exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf);
      end
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (nxt < 8) drive(1'b1, ba[nxt], bb[nxt], 1'b0, bs[nxt]);
      else         drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready[%0d]: got %b want 1", c, bus.in_ready); end
      tick();
      void'(exp_q.pop_front());
      if (nxt < 8) begin
        exp_q.push_back(ref_add(ba[nxt], bb[nxt], 1'b0, add_op_e'(bs[nxt])));
        nxt++;
      end
      checks++;
      if (exp_q.size() > 0) begin
        if (bus.out_valid !== 1'b1 || bus.sum !== exp_q[0].sum || bus.cout !== exp_q[0].cout || bus.ovf !== exp_q[0].ovf) begin
          failures++;
          $display("FAIL bp_drain[%0d]: got %b %h/%b/%b want 1 %h/%b/%b", c, bus.out_valid, bus.sum, bus.cout, bus.ovf,
                   exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf);
        end
      end else if (bus.out_valid !== 1'b0) begin
        failures++; $display("FAIL bp_drain_empty[%0d]: got out_valid=%b want 0", c, bus.out_valid);
      end
    end
    checks++;
    if (exp_q.size() != 0 || nxt != 8) begin
      failures++; $display("FAIL bp_complete: got pending=%0d sent=%0d want 0 8", exp_q.size(), nxt);
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0F0F_0F0F, 32'h0000_0001, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 32'h3333_3333) begin
      failures++; $display("FAIL mid_pre: got %b %h want 1 33333333", bus.out_valid, bus.sum);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.sum !== 32'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL mid_rst_data: got %h/%b/%b want 0/0/0", bus.sum, bus.cout, bus.ovf);
    end
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_dropped[%0d]: got %b want 0", c, bus.out_valid); end
    end
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0011, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (n != STAGES) begin failures++; $display("FAIL mid_latency: got %0d want %0d", n, STAGES); end
    checks++;
    if (bus.sum !== 32'hDEAD_BF01 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL mid_result: got %h/%b/%b want deadbf01/0/0", bus.sum, bus.cout, bus.ovf);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_single_add();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
- Parametrised, pipelined successor to the single-bit full-adder cell.
- Adds or subtracts two WIDTH-bit operands with carry-in.
- The carry chain is split into CHUNK-bit slices, with one register stage per slice.
- Full throughput of one operation per cycle, valid/ready handshake on both sides; sits in datapath/ALU front-ends that need a wide adder at high clock rate.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per pipeline stage (1..WIDTH).
- STAGES, WIDTH/CHUNK, localparam; pipeline depth and latency in cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB.
- ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- Reset is asynchronous, active-high, on clk domain only.
  - All stage valid bits, skew and deskew data registers, and carry registers clear.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 once rst deasserts.
- Operand conditioning happens at the input, combinationally:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - add: sum = a + b + cin. sub: sum = a - b - cin (two's complement).
- Stage k (0..STAGES-1) computes chunk k, bits [k*CHUNK +: CHUNK], using the carry registered by stage k-1 (stage 0 uses c0). It registers the chunk sum and its carry-out.
- Skew: chunk k of a/b_eff is delayed k cycles before entering stage k. Deskew: result chunk k is delayed STAGES-1-k cycles so all chunks emerge aligned.
- Latency is exactly STAGES cycles from accept (in_valid && in_ready) to out_valid, when not stalled.
- cout = carry out of the last stage.
- ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), evaluated with a_msb and b_eff_msb delayed alongside the MSB chunk.
- Handshake:
  - advance = out_ready || !out_valid; in_ready = advance.
  - All pipeline registers, including valid bits, update only when advance=1. Global stall: bubbles do not collapse.
  - When out_valid=1 && out_ready=0: sum, cout and ovf hold stable; in_ready=0.
  - a/b/cin/sub are sampled only on accept. A beat with in_valid=0 while advancing inserts a bubble (valid=0).
- Simultaneous accept and emit in the same cycle is legal and sustains one op per cycle.
- Wrap-around: results are modulo 2^WIDTH. 0xFFFFFFFF+1 gives sum=0, cout=1.
- Reset mid-operation drops all in-flight beats; no partial result is emitted.
- CHUNK==WIDTH degenerates to a single registered stage with latency 1.
- Elaboration error if WIDTH%CHUNK != 0 or CHUNK < 1.

Decomposition:
- Package adder_pkg holds:
  - typedef enum logic {ADD_OP=1'b0, SUB_OP=1'b1} add_op_e
  - a function computing the reference sum/cout/ovf for the bench scoreboard
  - the default WIDTH/CHUNK constants
- Sub-module adder_slice: CHUNK-bit combinational ripple of full-add cells (sum = a^b^c, carry = majority). It is instantiated once per stage by a generate loop.
- All registers stay in the top module.

Test Plan (WIDTH=32, CHUNK=8, STAGES=4):
- Reset then one add: a=0x0000_0003, b=0x0000_0004, cin=0, sub=0.
  - out_valid rises exactly 4 cycles after accept.
  - sum=0x0000_0007, cout=0, ovf=0.
- Full carry ripple across all chunks: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → sum=0x0000_0000, cout=1, ovf=0.
- Subtract and signed overflow:
  - a=0x8000_0000, b=0x0000_0001, sub=1, cin=0 → sum=0x7FFF_FFFF, ovf=1, cout=1.
  - a=0x7FFF_FFFF, b=0x0000_0001, sub=0 → sum=0x8000_0000, ovf=1.
- Back-to-back streaming: 100 random beats with out_ready=1.
  - One result per cycle after the 4-cycle fill, in order, all matching the adder_pkg model.
  - Include sub=1 with cin=1: a=10, b=3 → 6.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full.
  - in_ready=0 and sum/cout/ovf stable throughout.
  - Release: no beat lost or duplicated.
- Reset mid-stream: assert rst with 3 beats in flight.
  - out_valid=0 and sum=0 immediately (asynchronously).
  - After release, the first new beat emerges 4 cycles after accept with the correct result.
